// File: rtl/hazard_ctrl.sv
// Load-use stall, branch/jump squash sequencing for the IF/ID and ID/EX
// registers and the PC, plus saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_Jump,
  input  logic             EX_MemtoReg,
  input  logic             EX_RegWr,
  input  logic [4:0]       EX_rt,
  input  logic             EX_Branch_taken,
  output logic             PC_wr,
  output logic             IF_ID_wr,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             stalling,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  localparam logic [2:0]       REMAIN_INIT = 3'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [2:0]       remain_q, remain_d;
  logic             stalling_q, stalling_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;

  assign lu = EX_MemtoReg && EX_RegWr && (EX_rt != 5'd0) &&
              ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  always_comb begin
    PC_wr       = 1'b1;
    IF_ID_wr    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    state_d     = state_q;
    remain_d    = remain_q;

    if (reset) begin
      PC_wr       = 1'b0;
      IF_ID_wr    = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      state_d     = RUN;
      remain_d    = 3'd0;
    end else if (EX_Branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      state_d     = RUN;
      remain_d    = 3'd0;
    end else if (state_q == LU_STALL) begin
      PC_wr       = 1'b0;
      IF_ID_wr    = 1'b0;
      ID_EX_flush = 1'b1;
      if (remain_q <= 3'd1) begin
        state_d  = RUN;
        remain_d = 3'd0;
      end else begin
        remain_d = remain_q - 3'd1;
      end
    end else if (lu) begin
      // A pending jump is deliberately ignored here; it is seen again after the stall.
      PC_wr       = 1'b0;
      IF_ID_wr    = 1'b0;
      ID_EX_flush = 1'b1;
      if (LU_BUBBLES > 1) begin
        state_d  = LU_STALL;
        remain_d = REMAIN_INIT;
      end
    end else if (ID_Jump) begin
      IF_ID_flush = 1'b1;
    end
  end

  always_comb begin
    stalling_d  = (state_d == LU_STALL);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!reset && !PC_wr && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!reset && IF_ID_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      remain_q    <= 3'd0;
      stalling_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stalling_q  <= stalling_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stalling  = stalling_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances share stimulus
// (1 bubble, 3 bubbles, and a 2-bit counter variant).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jump, ex_memtoreg, ex_regwr, ex_branch_taken;

  logic        b1_pc_wr, b1_ifid_wr, b1_ifid_flush, b1_idex_flush, b1_stalling;
  logic [15:0] b1_stall_cnt, b1_flush_cnt;
  logic        b3_pc_wr, b3_ifid_wr, b3_ifid_flush, b3_idex_flush, b3_stalling;
  logic [15:0] b3_stall_cnt, b3_flush_cnt;
  logic        c2_pc_wr, c2_ifid_wr, c2_ifid_flush, c2_idex_flush, c2_stalling;
  logic [1:0]  c2_stall_cnt, c2_flush_cnt;

  logic [3:0] b1_ctl, b3_ctl, c2_ctl;
  assign b1_ctl = {b1_pc_wr, b1_ifid_wr, b1_ifid_flush, b1_idex_flush};
  assign b3_ctl = {b3_pc_wr, b3_ifid_wr, b3_ifid_flush, b3_idex_flush};
  assign c2_ctl = {c2_pc_wr, c2_ifid_wr, c2_ifid_flush, c2_idex_flush};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) u_b1 (
    .clk(clk), .reset(reset), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(id_uses_rt),
    .ID_Jump(id_jump), .EX_MemtoReg(ex_memtoreg), .EX_RegWr(ex_regwr), .EX_rt(ex_rt),
    .EX_Branch_taken(ex_branch_taken), .PC_wr(b1_pc_wr), .IF_ID_wr(b1_ifid_wr),
    .IF_ID_flush(b1_ifid_flush), .ID_EX_flush(b1_idex_flush), .stalling(b1_stalling),
    .stall_cnt(b1_stall_cnt), .flush_cnt(b1_flush_cnt));

  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(16)) u_b3 (
    .clk(clk), .reset(reset), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(id_uses_rt),
    .ID_Jump(id_jump), .EX_MemtoReg(ex_memtoreg), .EX_RegWr(ex_regwr), .EX_rt(ex_rt),
    .EX_Branch_taken(ex_branch_taken), .PC_wr(b3_pc_wr), .IF_ID_wr(b3_ifid_wr),
    .IF_ID_flush(b3_ifid_flush), .ID_EX_flush(b3_idex_flush), .stalling(b3_stalling),
    .stall_cnt(b3_stall_cnt), .flush_cnt(b3_flush_cnt));

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(id_uses_rt),
    .ID_Jump(id_jump), .EX_MemtoReg(ex_memtoreg), .EX_RegWr(ex_regwr), .EX_rt(ex_rt),
    .EX_Branch_taken(ex_branch_taken), .PC_wr(c2_pc_wr), .IF_ID_wr(c2_ifid_wr),
    .IF_ID_flush(c2_ifid_flush), .ID_EX_flush(c2_idex_flush), .stalling(c2_stalling),
    .stall_cnt(c2_stall_cnt), .flush_cnt(c2_flush_cnt));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives inputs just after a rising edge, then lets combinational outputs settle.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic jump, input logic mem2reg, input logic regwr,
                               input logic [4:0] xrt, input logic br);
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = uses_rt;
    id_jump         = jump;
    ex_memtoreg     = mem2reg;
    ex_regwr        = regwr;
    ex_rt           = xrt;
    ex_branch_taken = br;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    checkOutput("rst_ctl", 32'(b1_ctl), 32'b0011);
    tick();
    reset = 1'b0;
    idle();
    checkOutput("run_ctl", 32'(b1_ctl), 32'b1100);
    checkOutput("run_stall_cnt", 32'(b1_stall_cnt), 32'd0);
    checkOutput("run_flush_cnt", 32'(b1_flush_cnt), 32'd0);
    checkOutput("run_stalling", 32'(b3_stalling), 32'd0);

    // One-bubble load-use on rs
    applyStimulus(5'd5, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    checkOutput("lu1_ctl", 32'(b1_ctl), 32'b0001);
    tick();
    applyStimulus(5'd5, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("lu1_after_ctl", 32'(b1_ctl), 32'b1100);
    checkOutput("lu1_stall_cnt", 32'(b1_stall_cnt), 32'd1);
    checkOutput("lu1_stalling", 32'(b1_stalling), 32'd0);

    // Three-bubble load-use on rt
    doReset();
    applyStimulus(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    checkOutput("lu3_c1_ctl", 32'(b3_ctl), 32'b0001);
    checkOutput("lu3_c1_stalling", 32'(b3_stalling), 32'd0);
    tick();
    checkOutput("lu3_c2_ctl", 32'(b3_ctl), 32'b0001);
    checkOutput("lu3_c2_stalling", 32'(b3_stalling), 32'd1);
    tick();
    checkOutput("lu3_c3_ctl", 32'(b3_ctl), 32'b0001);
    checkOutput("lu3_c3_stalling", 32'(b3_stalling), 32'd1);
    tick();
    applyStimulus(5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("lu3_done_ctl", 32'(b3_ctl), 32'b1100);
    checkOutput("lu3_done_stalling", 32'(b3_stalling), 32'd0);
    checkOutput("lu3_stall_cnt", 32'(b3_stall_cnt), 32'd3);

    // No hazard: r0 destination, and rt match without rt use
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    checkOutput("nohz_r0_ctl", 32'(b3_ctl), 32'b1100);
    tick();
    applyStimulus(5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    checkOutput("nohz_rt_ctl", 32'(b3_ctl), 32'b1100);
    tick();
    idle();
    checkOutput("nohz_stall_cnt", 32'(b3_stall_cnt), 32'd0);

    // Branch taken in the second cycle of a three-bubble stall
    doReset();
    applyStimulus(5'd5, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    checkOutput("brst_c1_ctl", 32'(b3_ctl), 32'b0001);
    tick();
    applyStimulus(5'd5, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput("brst_c2_ctl", 32'(b3_ctl), 32'b1111);
    tick();
    idle();
    checkOutput("brst_after_ctl", 32'(b3_ctl), 32'b1100);
    checkOutput("brst_stalling", 32'(b3_stalling), 32'd0);
    checkOutput("brst_flush_cnt", 32'(b3_flush_cnt), 32'd1);
    checkOutput("brst_stall_cnt", 32'(b3_stall_cnt), 32'd1);

    // Jump together with a load-use: stall first, then squash
    doReset();
    applyStimulus(5'd5, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    checkOutput("jlu_c1_ctl", 32'(b1_ctl), 32'b0001);
    tick();
    applyStimulus(5'd5, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("jlu_c2_ctl", 32'(b1_ctl), 32'b1110);
    tick();
    idle();
    checkOutput("jlu_flush_cnt", 32'(b1_flush_cnt), 32'd1);
    checkOutput("jlu_stall_cnt", 32'(b1_stall_cnt), 32'd1);

    // Branch beats a jump in ID and counts once
    doReset();
    applyStimulus(5'd3, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput("brj_ctl", 32'(b1_ctl), 32'b1111);
    tick();
    idle();
    checkOutput("brj_flush_cnt", 32'(b1_flush_cnt), 32'd1);

    // Saturation of a 2-bit flush counter over five jumps
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'd3, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput($sformatf("jsat_ctl%0d", i), 32'(c2_ctl), 32'b1110);
      checkOutput($sformatf("jsat_cnt%0d", i), 32'(c2_flush_cnt), (i < 3) ? 32'(i) : 32'd3);
      tick();
    end
    idle();
    checkOutput("jsat_final", 32'(c2_flush_cnt), 32'd3);
    tick();
    checkOutput("jsat_hold", 32'(c2_flush_cnt), 32'd3);
    checkOutput("jsat_b1_cnt", 32'(b1_flush_cnt), 32'd5);

    // Reset mid-stall abandons the stall
    doReset();
    applyStimulus(5'd5, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    tick();
    reset = 1'b1;
    idle();
    checkOutput("rstmid_ctl", 32'(b3_ctl), 32'b0011);
    tick();
    reset = 1'b0;
    idle();
    checkOutput("rstmid_after_ctl", 32'(b3_ctl), 32'b1100);
    checkOutput("rstmid_stalling", 32'(b3_stalling), 32'd0);
    checkOutput("rstmid_stall_cnt", 32'(b3_stall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the IF/ID and ID/EX pipeline registers and the PC. It detects load-use hazards and inserts bubbles through `ID_EX_flush`. It squashes wrong-path instructions on taken branches (resolved in EX) and jumps (resolved in ID), and it keeps saturating performance counters for stall cycles and flush events. It sits beside the decode stage: it reads register indices from ID and control bits from the ID/EX register outputs, and it drives the write-enable and flush inputs of the PC, IF/ID and ID/EX registers.

## Interface
- `LU_BUBBLES`, default 1: bubbles inserted per load-use hazard; legal range 1..7.
- `CNT_W`, default 16: width of each performance counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ID_rs`  in  5  rs field of the instruction in ID.
- `ID_rt`  in  5  rt field of the instruction in ID.
- `ID_uses_rt`  in  1  instruction in ID reads rt as a source.
- `ID_Jump`  in  1  instruction in ID is a jump (j/jal/jr/jalr).
- `EX_MemtoReg`  in  1  instruction in EX is a load.
- `EX_RegWr`  in  1  instruction in EX writes the register file.
- `EX_rt`  in  5  destination register of the load in EX.
- `EX_Branch_taken`  in  1  branch in EX resolved taken this cycle.
- `PC_wr`  out  1  PC write enable.
- `IF_ID_wr`  out  1  IF/ID register write enable.
- `IF_ID_flush`  out  1  clears IF/ID on the next edge.
- `ID_EX_flush`  out  1  loads a bubble into ID/EX on the next edge.
- `stalling`  out  1  controller is in the LU_STALL state.
- `stall_cnt`  out  CNT_W  count of cycles with `PC_wr`=0 since reset; saturates.
- `flush_cnt`  out  CNT_W  count of branch and jump flush events since reset; saturates.

## Operation
- The control outputs are combinational (Mealy) functions of the state and the inputs. The state and counters are registers.
- States:
  - RUN (reset state).
  - LU_STALL, which holds a 3-bit down-counter `remain`.
- Load-use hazard: `lu` = `EX_MemtoReg` & `EX_RegWr` & (`EX_rt`≠0) & ((`EX_rt`==`ID_rs`) | (`ID_uses_rt` & `EX_rt`==`ID_rt`)).
- Output priority, highest first:
  1. `reset`=1: `PC_wr`=0, `IF_ID_wr`=0, `IF_ID_flush`=1, `ID_EX_flush`=1.
  2. `EX_Branch_taken`=1 (any state): `PC_wr`=1, `IF_ID_wr`=1, `IF_ID_flush`=1, `ID_EX_flush`=1. Next state is RUN and `remain` is cleared.
  3. State LU_STALL: `PC_wr`=0, `IF_ID_wr`=0, `IF_ID_flush`=0, `ID_EX_flush`=1.
  4. RUN with `lu`=1: same outputs as item 3. `ID_Jump` is ignored this cycle and is re-evaluated after the stall.
  5. RUN with `ID_Jump`=1: `PC_wr`=1, `IF_ID_wr`=1, `IF_ID_flush`=1, `ID_EX_flush`=0.
  6. Otherwise all enables are 1 and all flushes are 0.
- Transitions:
  - RUN with `lu`=1, no branch, and `LU_BUBBLES`>1: go to LU_STALL with `remain`=`LU_BUBBLES`-1.
  - RUN with `lu`=1 and `LU_BUBBLES`=1: stay in RUN. EX holds a bubble on the next cycle, so `lu` drops by itself.
  - LU_STALL: `remain` decrements each cycle. When `remain`==1, go to RUN on the next edge.
- Counters:
  - `stall_cnt` increments on every non-reset cycle with `PC_wr`=0.
  - `flush_cnt` increments on every non-reset cycle with `IF_ID_flush`=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset: state=RUN, `remain`=0, `stall_cnt`=0, `flush_cnt`=0, `stalling`=0. Reset asserted mid-stall abandons the stall on the next edge.

## Timing
- Hazard detection takes zero cycles: outputs react in the same cycle that `lu`, `EX_Branch_taken` or `ID_Jump` asserts.
- Load-use costs exactly `LU_BUBBLES` cycles. For those cycles `PC_wr`=0 and `ID_EX_flush`=1. The dependent instruction enters EX on the cycle after the last bubble.
- A taken branch costs 2 squashed slots (IF/ID and ID/EX) and no stall cycle.
- A jump costs 1 squashed slot (IF/ID).
- A branch taken while a jump sits in ID: the branch wins, and `flush_cnt` increments by 1, not 2.
- `stalling` is registered: it equals (state==LU_STALL), so it rises 1 cycle after hazard detection and only when `LU_BUBBLES`>1.

## Test plan
- Reset, then release: in the reset cycle `PC_wr`=0, `IF_ID_flush`=1 and `ID_EX_flush`=1. After release the outputs are 1/1/0/0 and both counters read 0.
- Load-use with `LU_BUBBLES`=1: `EX_MemtoReg`=1, `EX_RegWr`=1, `EX_rt`=5, `ID_rs`=5 → one cycle of `PC_wr`=0 and `ID_EX_flush`=1, then `stall_cnt`=1.
- Load-use with `LU_BUBBLES`=3 on `ID_rt`=5 and `ID_uses_rt`=1 → 3 cycles with `PC_wr`=0; `stalling`=1 for the 2nd and 3rd cycles; `stall_cnt`=3.
- No hazard cases: same setup with `EX_rt`=0, or with `ID_uses_rt`=0 and an rt-only match → no stall.
- `EX_Branch_taken`=1 in the 2nd cycle of a `LU_BUBBLES`=3 stall → that cycle has `PC_wr`=1 and both flushes asserted, the next state is RUN, and `flush_cnt`=1.
- `ID_Jump`=1 together with `lu`=1 → stall first with no IF/ID flush; on the next cycle `IF_ID_flush`=1. Separately, with `CNT_W`=2, 5 consecutive jumps → `flush_cnt`=3 and holds.
